// File: rtl/lv_ov_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lv_ov_pkg
// Brief    : Shared types and helpers for the LV supply over-voltage deglitch
//            path (state encoding, debounce cycle-count arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
package lv_ov_pkg;

  // Debug-visible state encoding of the OV deglitch FSM
  typedef enum logic [1:0] {
    NORM     = 2'd0,
    OV_PEND  = 2'd1,
    OV_ACT   = 2'd2,
    REL_PEND = 2'd3
  } ov_st_e;

  // Filter time in microseconds times clock in MHz gives the debounce length in clocks
  function automatic int deb_cycles(input int us, input int clk_m);
    return us * clk_m;
  endfunction

  // Larger of two counts; sizes the shared debounce counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lv_sync2.sv
`default_nettype none
// ============================================================================
// Module   : lv_sync2
// Brief    : Generic two-flop synchroniser for a single asynchronous bit,
//            with a configurable synchronous reset value.
// Revision : 1.0 - initial release
// ============================================================================
module lv_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // First flop may go metastable; second flop gives the settled copy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/lv_ov_deglitch.sv
`default_nettype none
// ============================================================================
// Module   : lv_ov_deglitch
// Brief    : LV supply over-voltage response path. Registers the BIST force
//            request to the analog comparator, synchronises the raw comparator
//            output and deglitches it into the lv_vsup_ov flag.
//            Optional macro LV_OV_LATCH_EN: keeps the flag sticky after OV_ACT
//            until cleared by i_ov_clr while the FSM is idle in NORM.
// Revision : 1.0 - initial release
// ============================================================================
module lv_ov_deglitch
  import lv_ov_pkg::*;
#(
  parameter int CLK_M      = 1,
  parameter int OV_DEB_US  = 10,
  parameter int REL_DEB_US = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bistlv_ov,
  input  logic       i_ov_raw,
  input  logic       i_ov_clr,
  output logic       o_ana_ov_frc,
  output logic       o_lv_vsup_ov,
  output logic [1:0] o_ov_st
);

  localparam int c_ov_deb_cyc  = deb_cycles(OV_DEB_US, CLK_M);
  localparam int c_rel_deb_cyc = deb_cycles(REL_DEB_US, CLK_M);
  localparam int CNT_W         = $clog2(max_int(c_ov_deb_cyc, c_rel_deb_cyc) + 1);

  localparam logic [CNT_W-1:0] c_ov_last  = CNT_W'(c_ov_deb_cyc - 1);
  localparam logic [CNT_W-1:0] c_rel_last = CNT_W'(c_rel_deb_cyc - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic             r_ana_ov_frc;
  logic             w_s_ov;
  ov_st_e           r_st;
  ov_st_e           w_st_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vsup;
  logic             w_sticky_nxt;

  // Force request is a plain one-cycle registered copy of the BIST request
  always_ff @(posedge i_clk) begin
    if (i_rst) r_ana_ov_frc <= 1'b0;
    else       r_ana_ov_frc <= i_bistlv_ov;
  end

  lv_sync2 #(
    .RST_VAL (1'b0)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ov_raw),
    .o_q   (w_s_ov)
  );

  // Next-state decode: pending states expire after their debounce count
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      NORM:     if (w_s_ov) w_st_nxt = OV_PEND;
      OV_PEND:  if (!w_s_ov)                w_st_nxt = NORM;
                else if (r_cnt == c_ov_last) w_st_nxt = OV_ACT;
      OV_ACT:   if (!w_s_ov) w_st_nxt = REL_PEND;
      REL_PEND: if (w_s_ov)                  w_st_nxt = OV_ACT;
                else if (r_cnt == c_rel_last) w_st_nxt = NORM;
      default:  w_st_nxt = NORM;
    endcase
  end

`ifdef LV_OV_LATCH_EN
  logic r_sticky;
  logic w_ent_act;

  assign w_ent_act = (w_st_nxt == OV_ACT) && (r_st != OV_ACT);

  // Entry into OV_ACT takes priority over a simultaneous clear
  always_comb begin
    w_sticky_nxt = r_sticky;
    if (w_ent_act)                      w_sticky_nxt = 1'b1;
    else if (i_ov_clr && (r_st == NORM)) w_sticky_nxt = 1'b0;
  end

  // Sticky OV memory survives the release debounce
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sticky <= 1'b0;
    else       r_sticky <= w_sticky_nxt;
  end
`else
  logic w_unused_ov_clr;

  assign w_sticky_nxt    = 1'b0;
  assign w_unused_ov_clr = i_ov_clr;
`endif

  // State, debounce counter and flag; counter restarts on every state change
  // (at 1 when entering a pending state so the entry cycle counts)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st   <= NORM;
      r_cnt  <= '0;
      r_vsup <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      if (w_st_nxt != r_st)
        r_cnt <= ((w_st_nxt == OV_PEND) || (w_st_nxt == REL_PEND)) ? c_cnt_one : '0;
      else
        r_cnt <= r_cnt + c_cnt_one;
      r_vsup <= w_sticky_nxt || (w_st_nxt == OV_ACT) || (w_st_nxt == REL_PEND);
    end
  end

  assign o_ana_ov_frc = r_ana_ov_frc;
  assign o_lv_vsup_ov = r_vsup;
  assign o_ov_st      = r_st;

endmodule
`default_nettype wire
